// File: rtl/math_addsub_wide_if.sv
// Operand/result bundle for the segmented wide adder/subtractor.
// W is the operand width; the result is one bit wider.
interface math_addsub_wide_if #(
    parameter int W = 96
);
    logic         ena;
    logic         din_valid;
    logic         sub;
    logic [W-1:0] dina;
    logic [W-1:0] dinb;
    logic [W:0]   dout;
    logic         dout_valid;

    modport master (
        output ena, din_valid, sub, dina, dinb,
        input  dout, dout_valid
    );

    modport slave (
        input  ena, din_valid, sub, dina, dinb,
        output dout, dout_valid
    );
endinterface

// File: rtl/math_addsub_wide.sv
// Pipelined W+1-bit exact add/subtract built from NSEG carry-chained SEG_W-bit segments.
// Latency is NSEG+2 enabled clocks; the sub and valid bits travel with each sample.
module math_addsub_wide #(
    parameter int SEG_W  = 48,
    parameter int NSEG   = 2,
    parameter int SIGNED = 0
) (
    input  logic              clk,
    input  logic              rst,
    math_addsub_wide_if.slave io
);
    localparam int W = SEG_W * NSEG;

    // Bank p holds a sample after p+1 enabled edges: result segments below p are
    // final, operand segments from p upward are still waiting for their adder.
    logic [SEG_W-1:0] a_q [NSEG+1][NSEG];
    logic [SEG_W-1:0] a_d [NSEG+1][NSEG];
    logic [SEG_W-1:0] b_q [NSEG+1][NSEG];
    logic [SEG_W-1:0] b_d [NSEG+1][NSEG];
    logic [SEG_W-1:0] r_q [NSEG+1][NSEG];
    logic [SEG_W-1:0] r_d [NSEG+1][NSEG];
    logic             c_q [NSEG+1];
    logic             c_d [NSEG+1];
    logic             s_q [NSEG+1];
    logic             s_d [NSEG+1];
    logic             v_q [NSEG+1];
    logic             v_d [NSEG+1];

    logic [SEG_W:0]   seg_sum [NSEG];
    logic [SEG_W-1:0] b_eff   [NSEG];

    logic             top_a;
    logic             top_b;
    logic [W:0]       dout_d;
    logic [W:0]       dout_q;
    logic             dout_valid_q;

    always_comb begin
        // Bank 0: the carry-in of segment 0 is the sub bit, supplying the +1 of a - b.
        for (int j = 0; j < NSEG; j++) begin
            a_d[0][j] = io.dina[j*SEG_W +: SEG_W];
            b_d[0][j] = io.dinb[j*SEG_W +: SEG_W];
            r_d[0][j] = '0;
        end
        c_d[0] = io.sub;
        s_d[0] = io.sub;
        v_d[0] = io.din_valid;

        for (int p = 1; p <= NSEG; p++) begin
            for (int j = 0; j < NSEG; j++) begin
                a_d[p][j] = a_q[p-1][j];
                b_d[p][j] = b_q[p-1][j];
                r_d[p][j] = r_q[p-1][j];
            end
            b_eff[p-1]   = s_q[p-1] ? ~b_q[p-1][p-1] : b_q[p-1][p-1];
            seg_sum[p-1] = {1'b0, a_q[p-1][p-1]} + {1'b0, b_eff[p-1]}
                         + {{SEG_W{1'b0}}, c_q[p-1]};
            r_d[p][p-1]  = seg_sum[p-1][SEG_W-1:0];
            c_d[p]       = seg_sum[p-1][SEG_W];
            s_d[p]       = s_q[p-1];
            v_d[p]       = v_q[p-1];
        end
    end

    // Bit W: extension bits of a and of the (possibly inverted) b plus the final carry.
    always_comb begin
        dout_d = '0;
        top_a  = (SIGNED != 0) ? a_q[NSEG][NSEG-1][SEG_W-1] : 1'b0;
        top_b  = (SIGNED != 0) ? b_q[NSEG][NSEG-1][SEG_W-1] : 1'b0;
        for (int j = 0; j < NSEG; j++) begin
            dout_d[j*SEG_W +: SEG_W] = r_q[NSEG][j];
        end
        dout_d[W] = top_a ^ top_b ^ s_q[NSEG] ^ c_q[NSEG];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int p = 0; p <= NSEG; p++) begin
                for (int j = 0; j < NSEG; j++) begin
                    a_q[p][j] <= '0;
                    b_q[p][j] <= '0;
                    r_q[p][j] <= '0;
                end
                c_q[p] <= 1'b0;
                s_q[p] <= 1'b0;
                v_q[p] <= 1'b0;
            end
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
        end else if (io.ena) begin
            for (int p = 0; p <= NSEG; p++) begin
                for (int j = 0; j < NSEG; j++) begin
                    a_q[p][j] <= a_d[p][j];
                    b_q[p][j] <= b_d[p][j];
                    r_q[p][j] <= r_d[p][j];
                end
                c_q[p] <= c_d[p];
                s_q[p] <= s_d[p];
                v_q[p] <= v_d[p];
            end
            dout_q       <= dout_d;
            dout_valid_q <= v_q[NSEG];
        end
    end

    assign io.dout       = dout_q;
    assign io.dout_valid = dout_valid_q;
endmodule

// File: tb/tb_math_addsub_wide.sv
// Bench for two configurations: 2x48 unsigned (latency 4) and 4x8 signed (latency 6).
// Each DUT is checked every cycle against an exact-arithmetic delay-line model.
module tb_math_addsub_wide;
    localparam int LAT0 = 4;
    localparam int LAT1 = 6;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic ena = 1'b1;
    logic run = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    math_addsub_wide_if #(.W(96)) if0 ();
    math_addsub_wide_if #(.W(32)) if1 ();

    assign if0.ena = ena;
    assign if1.ena = ena;

    math_addsub_wide #(.SEG_W(48), .NSEG(2), .SIGNED(0)) u0 (.clk(clk), .rst(rst), .io(if0));
    math_addsub_wide #(.SEG_W(8),  .NSEG(4), .SIGNED(1)) u1 (.clk(clk), .rst(rst), .io(if1));

    function automatic logic [96:0] f0(input logic [95:0] a, input logic [95:0] b, input logic s);
        logic [96:0] ea, eb;
        ea = {1'b0, a};
        eb = {1'b0, b};
        return s ? ea - eb : ea + eb;
    endfunction

    function automatic logic [32:0] f1(input logic [31:0] a, input logic [31:0] b, input logic s);
        logic [32:0] ea, eb;
        ea = {a[31], a};
        eb = {b[31], b};
        return s ? ea - eb : ea + eb;
    endfunction

    logic [96:0] m0_d [LAT0];
    logic        m0_v [LAT0];
    logic [32:0] m1_d [LAT1];
    logic        m1_v [LAT1];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LAT0; i++) begin m0_d[i] <= '0; m0_v[i] <= 1'b0; end
            for (int i = 0; i < LAT1; i++) begin m1_d[i] <= '0; m1_v[i] <= 1'b0; end
        end else if (ena) begin
            for (int i = LAT0-1; i > 0; i--) begin m0_d[i] <= m0_d[i-1]; m0_v[i] <= m0_v[i-1]; end
            for (int i = LAT1-1; i > 0; i--) begin m1_d[i] <= m1_d[i-1]; m1_v[i] <= m1_v[i-1]; end
            m0_d[0] <= f0(if0.dina, if0.dinb, if0.sub);
            m0_v[0] <= if0.din_valid;
            m1_d[0] <= f1(if1.dina, if1.dinb, if1.sub);
            m1_v[0] <= if1.din_valid;
        end
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (run) begin
            chk("model_dout0",  128'(if0.dout),       128'(m0_d[LAT0-1]));
            chk("model_valid0", 128'(if0.dout_valid), 128'(m0_v[LAT0-1]));
            chk("model_dout1",  128'(if1.dout),       128'(m1_d[LAT1-1]));
            chk("model_valid1", 128'(if1.dout_valid), 128'(m1_v[LAT1-1]));
        end
    end

    task automatic drive(input logic [95:0] a0, input logic [95:0] b0, input logic s0, input logic v0,
                         input logic [31:0] a1, input logic [31:0] b1, input logic s1, input logic v1);
        if0.dina = a0; if0.dinb = b0; if0.sub = s0; if0.din_valid = v0;
        if1.dina = a1; if1.dinb = b1; if1.sub = s1; if1.din_valid = v1;
    endtask

    task automatic idle();
        drive('0, '0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    endtask

    // One isolated sample into each DUT, then literal checks at exact latency.
    task automatic vec(input string nm,
                       input logic [95:0] a0, input logic [95:0] b0, input logic s0, input logic [96:0] e0,
                       input logic [31:0] a1, input logic [31:0] b1, input logic s1, input logic [32:0] e1);
        @(negedge clk);
        drive(a0, b0, s0, 1'b1, a1, b1, s1, 1'b1);
        @(negedge clk);
        idle();
        repeat (LAT0-1) @(negedge clk);
        chk({nm, "_dout0"},  128'(if0.dout), 128'(e0));
        chk({nm, "_valid0"}, 128'(if0.dout_valid), 128'd1);
        repeat (LAT1-LAT0) @(negedge clk);
        chk({nm, "_dout1"},  128'(if1.dout), 128'(e1));
        chk({nm, "_valid1"}, 128'(if1.dout_valid), 128'd1);
    endtask

    logic [96:0] q0 [$];
    logic [32:0] q1 [$];
    logic [96:0] stall_e0 [3];
    logic [32:0] stall_e1 [3];

    initial begin
        idle();
        #1 rst = 1'b1;
        #2;
        chk("reset_dout0",  128'(if0.dout), 128'd0);
        chk("reset_valid1", 128'(if1.dout_valid), 128'd0);
        @(negedge clk);
        rst = 1'b0;
        run = 1'b1;
        repeat (2) @(negedge clk);

        vec("carry_ripple", 96'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 96'd1, 1'b0, 97'h1_0000_0000_0000_0000_0000_0000,
                            32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 33'h1_7FFF_FFFF);
        vec("borrow",       96'd5, 96'd7, 1'b1, 97'h1_FFFF_FFFF_FFFF_FFFF_FFFF_FFFE,
                            32'h7FFF_FFFF, 32'd1, 1'b0, 33'h0_8000_0000);
        vec("equal_sub",    96'h8000_0000_0000_0000_0000_0000, 96'h8000_0000_0000_0000_0000_0000, 1'b1, 97'h0,
                            32'd1, 32'd2, 1'b1, 33'h1_FFFF_FFFF);
        vec("pos_sub",      96'd7, 96'd5, 1'b1, 97'd2,
                            32'h8000_0000, 32'd1, 1'b1, 33'h1_7FFF_FFFF);

        // Stall with three samples in flight.
        stall_e0[0] = 97'd2;  stall_e0[1] = 97'd5;  stall_e0[2] = 97'd6;
        stall_e1[0] = 33'h1_FFFF_FFFE; stall_e1[1] = 33'h1_FFFF_FF9C; stall_e1[2] = 33'd10;
        @(negedge clk);
        drive(96'd1,  96'd1, 1'b0, 1'b1, 32'hFFFF_FFFD, 32'd1,   1'b0, 1'b1);
        @(negedge clk);
        drive(96'd2,  96'd3, 1'b0, 1'b1, 32'd100,       32'd200, 1'b1, 1'b1);
        @(negedge clk);
        drive(96'd10, 96'd4, 1'b1, 1'b1, 32'd5,         32'd5,   1'b0, 1'b1);
        @(negedge clk);
        idle();
        ena = 1'b0;
        for (int k = 0; k < 14; k++) begin
            if (k == 3) ena = 1'b1;
            if (if0.dout_valid) q0.push_back(if0.dout);
            if (if1.dout_valid) q1.push_back(if1.dout);
            @(negedge clk);
        end
        chk("stall_count0", 128'(q0.size()), 128'd3);
        chk("stall_count1", 128'(q1.size()), 128'd3);
        for (int i = 0; i < 3; i++) begin
            chk("stall_order0", (i < q0.size()) ? 128'(q0[i]) : 128'hX, 128'(stall_e0[i]));
            chk("stall_order1", (i < q1.size()) ? 128'(q1[i]) : 128'hX, 128'(stall_e1[i]));
        end

        // Back-to-back random traffic, add/sub alternating every cycle.
        for (int i = 0; i < 1000; i++) begin
            logic [95:0] ra, rb;
            logic [31:0] sa, sb;
            @(negedge clk);
            ra = {$urandom, $urandom, $urandom};
            rb = {$urandom, $urandom, $urandom};
            sa = $urandom;
            sb = $urandom;
            if ($urandom_range(0, 7) == 0) begin ra = '1; sa = 32'h8000_0000; end
            if ($urandom_range(0, 7) == 0) begin rb = '1; sb = 32'h7FFF_FFFF; end
            drive(ra, rb, i[0], 1'($urandom_range(0, 1)), sa, sb, ~i[0], 1'($urandom_range(0, 1)));
        end
        @(negedge clk);
        idle();
        repeat (LAT1 + 2) @(negedge clk);

        // Asynchronous reset between edges with valid samples in flight.
        drive(96'd11, 96'd22, 1'b0, 1'b1, 32'd3, 32'd4, 1'b1, 1'b1);
        @(negedge clk);
        drive(96'd33, 96'd44, 1'b1, 1'b1, 32'd5, 32'd6, 1'b0, 1'b1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        idle();
        #1;
        chk("async_rst_dout0",  128'(if0.dout),       128'd0);
        chk("async_rst_valid0", 128'(if0.dout_valid), 128'd0);
        chk("async_rst_dout1",  128'(if1.dout),       128'd0);
        chk("async_rst_valid1", 128'(if1.dout_valid), 128'd0);
        #1;
        rst = 1'b0;
        vec("after_rst", 96'h123, 96'h23, 1'b1, 97'h100,
                         32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 33'h1_FFFF_FFFE);
        repeat (LAT1 + 2) @(negedge clk);

        run = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
